// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: scans all 16 {a,b,c,d} inputs of a combinational block, captures F and compares to an expected table.
// Parameter SETTLE_CYCLES (1..15): cycles each combination is held before f_in is sampled.
// Ports: clk, reset (sync, active-high), start, abort, expected[15:0], f_in ->
//        abcd[3:0], busy, done, table_out[15:0], mismatch, err_count[4:0].
// Optional macro TRUTH_TABLE_COMPARE_EN enables the mismatch/err_count comparison; otherwise both stay 0.
module truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        mismatch,
  output logic [4:0]  err_count
);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  state_t state, state_next;
  logic [3:0] idx;
  logic [3:0] settle;
  logic settled;
  logic capture;
  logic cmp_mismatch;
  logic [4:0] cmp_count;
`ifdef TRUTH_TABLE_COMPARE_EN
  logic [15:0] diff;
  always_comb begin
    diff = table_out ^ expected;
    cmp_count = '0;
    for (int i = 0; i < 16; i++) cmp_count = cmp_count + 5'(diff[i]);
    cmp_mismatch = |diff;
  end
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign cmp_mismatch = 1'b0;
  assign cmp_count = '0;
`endif
  always_comb begin
    state_next = state;
    settled = settle == 4'(SETTLE_CYCLES - 1);
    capture = 1'b0;
    case (state)
      IDLE:    state_next = start ? APPLY : IDLE;
      APPLY:   state_next = abort ? IDLE : settled ? SAMPLE : APPLY;
      SAMPLE: begin
        state_next = abort ? IDLE : idx == 4'd15 ? DONE : APPLY;
        capture = !abort;
      end
      default: state_next = IDLE;
    endcase
    busy = state == APPLY || state == SAMPLE;
    abcd = busy ? idx : 4'd0;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      settle <= '0;
      table_out <= '0;
      mismatch <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        idx <= '0;
        settle <= '0;
        table_out <= '0;
        mismatch <= 1'b0;
        err_count <= '0;
      end
      if (state == APPLY) settle <= (settled || abort) ? 4'd0 : settle + 4'd1;
      // idx saturates at 15; the scan ends there instead of wrapping
      if (capture) begin
        table_out[idx] <= f_in;
        idx <= idx + 4'(idx != 4'd15);
      end
      if (state == DONE) begin
        mismatch <= cmp_mismatch;
        err_count <= cmp_count;
      end
    end
  end
endmodule
